fp_int_mac_seq: RTL and testbench

- Dot-product sequencer in front of one bit-serial fp16 x intN MAC.
- Accepts a job (length, exponent setting, initial accumulator), then pulls LEN activation/weight pairs over a valid/ready stream.
- Serialises each weight MSB-first onto the MAC's 1-bit weight input, waits for the MAC's done, and feeds the returned accumulator into the next element.
- Returns the final accumulator/exponent over a valid/ready result port, with a done-timeout watchdog.

---
 rtl/fp_int_pkg.sv | 16 +
 rtl/fp_int_mac_seq_if.sv | 47 ++++
 rtl/fp_int_bit_serializer.sv | 54 +++++
 rtl/fp_int_mac_seq.sv | 127 ++++++++++++
 tb/tb_fp_int_mac_seq.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fp_int_pkg.sv
// Shared constants for the fp16 x intN dot-product sequencer: FSM state
// encodings and fp16 field widths.
package fp_int_pkg;
    localparam int EXP_WIDTH  = 5;
    localparam int FP16_SGN_W = 1;
    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;

    localparam int ST_W = 3;
    typedef logic [ST_W-1:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_FEED = 3'd2;
    localparam state_t ST_WAIT = 3'd3;
    localparam state_t ST_OUT  = 3'd4;
endpackage

// File: rtl/fp_int_mac_seq_if.sv
// Job, element stream, MAC and result signals of the sequencer. The
// sequencer itself uses the slave view; its environment uses master.
interface fp_int_mac_seq_if #(
    parameter int PRECISION = 4,
    parameter int ACT_WIDTH = 16,
    parameter int ACC_WIDTH = 32,
    parameter int LEN_WIDTH = 8
);
    import fp_int_pkg::*;

    logic                 start;
    logic [LEN_WIDTH-1:0] len;
    logic [EXP_WIDTH-1:0] exp_set;
    logic [ACC_WIDTH-1:0] acc_init;
    logic                 busy;
    logic                 in_valid;
    logic                 in_ready;
    logic [ACT_WIDTH-1:0] in_act;
    logic [PRECISION-1:0] in_w;
    logic                 mac_valid;
    logic [ACT_WIDTH-1:0] mac_act;
    logic                 mac_w;
    logic [EXP_WIDTH-1:0] mac_exp_set;
    logic [ACC_WIDTH-1:0] mac_acc;
    logic                 mac_done;
    logic [EXP_WIDTH-1:0] mac_exp_out;
    logic [ACC_WIDTH-1:0] mac_fixed_point_out;
    logic                 res_valid;
    logic                 res_ready;
    logic [ACC_WIDTH-1:0] res_acc;
    logic [EXP_WIDTH-1:0] res_exp;
    logic                 res_err;

    modport slave (
        input  start, len, exp_set, acc_init, in_valid, in_act, in_w,
               mac_done, mac_exp_out, mac_fixed_point_out, res_ready,
        output busy, in_ready, mac_valid, mac_act, mac_w, mac_exp_set,
               mac_acc, res_valid, res_acc, res_exp, res_err
    );

    modport master (
        output start, len, exp_set, acc_init, in_valid, in_act, in_w,
               mac_done, mac_exp_out, mac_fixed_point_out, res_ready,
        input  busy, in_ready, mac_valid, mac_act, mac_w, mac_exp_set,
               mac_acc, res_valid, res_acc, res_exp, res_err
    );
endinterface

// File: rtl/fp_int_bit_serializer.sv
// Shifts a PRECISION-bit weight out MSB-first, one bit per cycle, with a
// registered valid that stays high for exactly PRECISION cycles after load.
module fp_int_bit_serializer #(
    parameter int PRECISION = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [PRECISION-1:0] w_i,
    output logic                 valid_o,
    output logic                 bit_o,
    output logic                 last_bit_o
);
    localparam int CW = (PRECISION > 1) ? $clog2(PRECISION) : 1;

    logic [PRECISION-1:0] sh_q, sh_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 valid_q, valid_d;

    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            sh_d    = w_i;
            cnt_d   = CW'(PRECISION - 1);
            valid_d = 1'b1;
        end else if (valid_q) begin
            if (cnt_q == '0) begin
                valid_d = 1'b0;
                sh_d    = '0;
            end else begin
                sh_d  = sh_q << 1;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o    = valid_q;
    assign bit_o      = sh_q[PRECISION-1];
    assign last_bit_o = valid_q && (cnt_q == '0);
endmodule

// File: rtl/fp_int_mac_seq.sv
// Dot-product sequencer: pulls LEN activation/weight pairs, streams each
// weight bit-serially into the MAC and chains its accumulator result.
module fp_int_mac_seq
    import fp_int_pkg::*;
#(
    parameter int PRECISION    = 4,
    parameter int ACT_WIDTH    = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int LEN_WIDTH    = 8,
    parameter int DONE_TIMEOUT = 64
) (
    input logic              clk,
    input logic              rst,
    fp_int_mac_seq_if.slave  bus
);
    localparam int WCW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] elem_cnt_q, elem_cnt_d;
    logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [ACT_WIDTH-1:0] act_q, act_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic                 err_q, err_d;
    logic                 busy_q, in_ready_q, res_valid_q;
    logic                 in_fire, ser_valid, ser_bit, ser_last;

    // in_ready_q is high exactly while in LOAD
    assign in_fire = in_ready_q & bus.in_valid;

    fp_int_bit_serializer #(.PRECISION(PRECISION)) u_ser (
        .clk        (clk),
        .rst        (rst),
        .load_i     (in_fire),
        .w_i        (bus.in_w),
        .valid_o    (ser_valid),
        .bit_o      (ser_bit),
        .last_bit_o (ser_last)
    );

    always_comb begin
        state_d    = state_q;
        elem_cnt_d = elem_cnt_q;
        wait_cnt_d = wait_cnt_q;
        act_d      = act_q;
        acc_d      = acc_q;
        exp_d      = exp_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                acc_d      = bus.acc_init;
                exp_d      = bus.exp_set;
                err_d      = 1'b0;
                elem_cnt_d = bus.len;
                state_d    = (bus.len == '0) ? ST_OUT : ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.mac_done) err_d = 1'b1;
                if (in_fire) begin
                    act_d   = bus.in_act;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                if (bus.mac_done) err_d = 1'b1;
                if (ser_last) begin
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mac_done) begin
                    acc_d      = bus.mac_fixed_point_out;
                    exp_d      = bus.mac_exp_out;
                    elem_cnt_d = elem_cnt_q - 1'b1;
                    state_d    = (elem_cnt_q == LEN_WIDTH'(1)) ? ST_OUT : ST_LOAD;
                end else if (wait_cnt_q == WCW'(DONE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_OUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            // a stray done here is dropped so the presented result stays stable
            ST_OUT: if (bus.res_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            elem_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            act_q       <= '0;
            acc_q       <= '0;
            exp_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            act_q       <= act_d;
            acc_q       <= acc_d;
            exp_q       <= exp_d;
            err_q       <= err_d;
            busy_q      <= (state_d != ST_IDLE);
            in_ready_q  <= (state_d == ST_LOAD);
            res_valid_q <= (state_d == ST_OUT);
        end
    end

    assign bus.busy        = busy_q;
    assign bus.in_ready    = in_ready_q;
    assign bus.mac_valid   = ser_valid;
    assign bus.mac_w       = ser_bit;
    assign bus.mac_act     = act_q;
    assign bus.mac_exp_set = exp_q;
    assign bus.mac_acc     = acc_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_acc     = acc_q;
    assign bus.res_exp     = exp_q;
    assign bus.res_err     = err_q;
endmodule

// File: tb/tb_fp_int_mac_seq.sv
// Directed bench for fp_int_mac_seq: expected results are queued at job
// issue and compared by an independent result monitor.
module tb_fp_int_mac_seq;
    localparam int P  = 4;
    localparam int TO = 64;

    typedef struct packed {
        logic [31:0] acc;
        logic [4:0]  exp;
        logic        err;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    res_t expq[$];
    res_t mon_e;

    always #5 clk = ~clk;

    fp_int_mac_seq_if #(.PRECISION(P), .ACT_WIDTH(16), .ACC_WIDTH(32), .LEN_WIDTH(8)) bus ();

    fp_int_mac_seq #(
        .PRECISION(P), .ACT_WIDTH(16), .ACC_WIDTH(32), .LEN_WIDTH(8), .DONE_TIMEOUT(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
        end
    endtask

    // inputs change 2 time units after the active edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) hs_cnt <= hs_cnt + 1;
    end

    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            if (expq.size() == 0) begin
                chk("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = expq.pop_front();
                chk("res_acc", bus.res_acc, mon_e.acc);
                chk("res_exp", 32'(bus.res_exp), 32'(mon_e.exp));
                chk("res_err", 32'(bus.res_err), 32'(mon_e.err));
            end
        end
    end

    task automatic start_job(input logic [7:0] l, input logic [4:0] e, input logic [31:0] a);
        bus.start = 1'b1; bus.len = l; bus.exp_set = e; bus.acc_init = a;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send_elem(input logic [15:0] act, input logic [P-1:0] w,
                             input logic [31:0] e_acc, input logic [4:0] e_exp,
                             input bit do_done, input logic [31:0] r_acc, input logic [4:0] r_exp);
        int n;
        bus.in_act = act; bus.in_w = w; bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin step(); n++; end
        chk("in_ready_seen", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        for (int b = P - 1; b >= 0; b--) begin
            chk("mac_valid_hi", 32'(bus.mac_valid), 32'd1);
            chk("mac_w", 32'(bus.mac_w), 32'(w[b]));
            chk("mac_act", 32'(bus.mac_act), 32'(act));
            chk("mac_acc", bus.mac_acc, e_acc);
            chk("mac_exp_set", 32'(bus.mac_exp_set), 32'(e_exp));
            step();
        end
        chk("mac_valid_lo", 32'(bus.mac_valid), 32'd0);
        if (do_done) begin
            step();
            bus.mac_done = 1'b1; bus.mac_fixed_point_out = r_acc; bus.mac_exp_out = r_exp;
            step();
            bus.mac_done = 1'b0;
        end
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        while (!bus.res_valid && n < 300) begin step(); n++; end
        chk("res_valid_seen", 32'(bus.res_valid), 32'd1);
        step();
        chk("idle_after_result", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n, hs0;
        bus.start = 0; bus.len = 0; bus.exp_set = 0; bus.acc_init = 0;
        bus.in_valid = 0; bus.in_act = 0; bus.in_w = 0;
        bus.mac_done = 0; bus.mac_exp_out = 0; bus.mac_fixed_point_out = 0;
        bus.res_ready = 1'b1;
        step(); step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_mac_valid", 32'(bus.mac_valid), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_acc", bus.res_acc, 32'd0);
        rst = 1'b0;
        step();

        // 1: single element, bit order and held operands
        expq.push_back('{acc: 32'h55, exp: 5'd3, err: 1'b0});
        start_job(8'd1, 5'd15, 32'd0);
        chk("busy_in_job", 32'(bus.busy), 32'd1);
        send_elem(16'h3C00, 4'b0101, 32'd0, 5'd15, 1'b1, 32'h55, 5'd3);
        wait_res();

        // 2: three elements, accumulator chaining
        hs0 = hs_cnt;
        expq.push_back('{acc: 32'd300, exp: 5'd5, err: 1'b0});
        start_job(8'd3, 5'd10, 32'd0);
        send_elem(16'h4000, 4'b1000, 32'd0,   5'd10, 1'b1, 32'd100, 5'd3);
        send_elem(16'h4200, 4'b0111, 32'd100, 5'd3,  1'b1, 32'd200, 5'd4);
        send_elem(16'hC000, 4'b1111, 32'd200, 5'd4,  1'b1, 32'd300, 5'd5);
        wait_res();
        chk("handshakes_len3", 32'(hs_cnt - hs0), 32'd3);

        // 3: zero-length job
        expq.push_back('{acc: 32'h1234, exp: 5'd7, err: 1'b0});
        start_job(8'd0, 5'd7, 32'h1234);
        chk("len0_res_valid", 32'(bus.res_valid), 32'd1);
        chk("len0_no_mac", 32'(bus.mac_valid), 32'd0);
        wait_res();

        // 4: watchdog, then a clean job
        expq.push_back('{acc: 32'hAB, exp: 5'd9, err: 1'b1});
        start_job(8'd1, 5'd9, 32'hAB);
        send_elem(16'h3800, 4'b0011, 32'hAB, 5'd9, 1'b0, 32'd0, 5'd0);
        n = 0;
        while (!bus.res_valid && n < 200) begin step(); n++; end
        chk("timeout_latency", 32'(n), 32'(TO));
        wait_res();
        expq.push_back('{acc: 32'h66, exp: 5'd1, err: 1'b0});
        start_job(8'd1, 5'd2, 32'd0);
        send_elem(16'h3C00, 4'b1010, 32'd0, 5'd2, 1'b1, 32'h66, 5'd1);
        wait_res();

        // 5: backpressure, ignored starts, stray done in LOAD
        bus.res_ready = 1'b0;
        expq.push_back('{acc: 32'd20, exp: 5'd4, err: 1'b1});
        start_job(8'd2, 5'd9, 32'd5);
        bus.start = 1'b1; bus.mac_done = 1'b1;
        bus.mac_fixed_point_out = 32'hDEAD; bus.mac_exp_out = 5'd31;
        step();
        bus.start = 1'b0; bus.mac_done = 1'b0;
        chk("stray_done_err", 32'(bus.res_err), 32'd1);
        chk("stray_done_acc", bus.mac_acc, 32'd5);
        chk("start_in_load_ignored", 32'(bus.in_ready), 32'd1);
        send_elem(16'h3C00, 4'b0001, 32'd5,  5'd9, 1'b1, 32'd10, 5'd2);
        send_elem(16'h3C00, 4'b0010, 32'd10, 5'd2, 1'b1, 32'd20, 5'd4);
        n = 0;
        while (!bus.res_valid && n < 50) begin step(); n++; end
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_res_valid", 32'(bus.res_valid), 32'd1);
            chk("hold_res_acc", bus.res_acc, 32'd20);
            chk("hold_res_exp", 32'(bus.res_exp), 32'd4);
            chk("hold_res_err", 32'(bus.res_err), 32'd1);
            chk("hold_busy", 32'(bus.busy), 32'd1);
            step();
            bus.start = 1'b0;
        end
        bus.res_ready = 1'b1;
        step();
        chk("bp_idle", 32'(bus.busy), 32'd0);
        step();
        chk("start_in_out_not_queued", 32'(bus.busy), 32'd0);

        // 6: reset in the middle of FEED
        start_job(8'd1, 5'd3, 32'h77);
        bus.in_act = 16'h3C00; bus.in_w = 4'b1100; bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin step(); n++; end
        step();
        bus.in_valid = 1'b0;
        step();
        chk("feed2_mac_valid", 32'(bus.mac_valid), 32'd1);
        rst = 1'b1;
        step();
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mrst_mac_valid", 32'(bus.mac_valid), 32'd0);
        chk("mrst_mac_w", 32'(bus.mac_w), 32'd0);
        chk("mrst_mac_act", 32'(bus.mac_act), 32'd0);
        chk("mrst_mac_acc", bus.mac_acc, 32'd0);
        chk("mrst_mac_exp_set", 32'(bus.mac_exp_set), 32'd0);
        chk("mrst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("mrst_res_acc", bus.res_acc, 32'd0);
        chk("mrst_res_exp", 32'(bus.res_exp), 32'd0);
        chk("mrst_res_err", 32'(bus.res_err), 32'd0);
        rst = 1'b0;
        step();
        expq.push_back('{acc: 32'h99, exp: 5'd8, err: 1'b0});
        start_job(8'd1, 5'd6, 32'd0);
        send_elem(16'h4400, 4'b0110, 32'd0, 5'd6, 1'b1, 32'h99, 5'd8);
        wait_res();

        step();
        chk("sb_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
